// File: rtl/lcd_cmd_sched.sv
// lcd_cmd_sched: in-order command FIFO feeding LCD_CTRL one command at a time.
// Each command is strobed for one cycle, then the scheduler waits for the
// controller's busy handshake before issuing the next. CMD_WRITE ends the run:
// once its write-back completes (lcd_done) the block parks in FINISH until reset.
module lcd_cmd_sched #(
    parameter int         DEPTH     = 8,
    parameter logic [3:0] CMD_WRITE = 4'd0,
    parameter int         BUSY_WIN  = 2
) (
    input  logic       clk,
    input  logic       reset,
    input  logic [3:0] host_cmd,
    input  logic       host_valid,
    output logic       host_ready,
    output logic [3:0] lcd_cmd,
    output logic       lcd_cmd_valid,
    input  logic       lcd_busy,
    input  logic       lcd_done,
    output logic [4:0] fifo_count,
    output logic [7:0] issued_cnt,
    output logic       sched_done,
    output logic       ovf_err
);

    localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int TW = (BUSY_WIN > 1) ? $clog2(BUSY_WIN + 1) : 1;

    typedef enum logic [2:0] {
        IDLE,
        ISSUE,
        WAIT_BUSY,
        WAIT_IDLE,
        WAIT_DONE,
        FINISH
    } state_t;

    state_t         state;
    logic [3:0]     mem [DEPTH];
    logic [AW-1:0]  wr_ptr;
    logic [AW-1:0]  rd_ptr;
    logic [TW-1:0]  tmr;       // cycles spent in WAIT_BUSY with busy still low
    logic           is_write;  // command in flight is CMD_WRITE
    logic           push;
    logic           pop;

    // Ready depends only on registered state, so the host sees no comb path from its own valid.
    assign host_ready = (fifo_count < 5'(DEPTH)) && !sched_done;
    assign push       = host_valid && host_ready;
    // The head leaves the FIFO on the edge that exits ISSUE.
    assign pop        = (state == ISSUE);

    // Command storage; contents need no reset since the pointers define validity.
    always_ff @(posedge clk) begin
        if (push) mem[wr_ptr] <= host_cmd;
    end

    // Circular pointers and occupancy; push+pop on one edge leaves the count unchanged.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            wr_ptr     <= '0;
            rd_ptr     <= '0;
            fifo_count <= '0;
        end else begin
            if (push) wr_ptr <= wr_ptr + 1'b1;
            if (pop)  rd_ptr <= rd_ptr + 1'b1;
            case ({push, pop})
                2'b10:   fifo_count <= fifo_count + 5'd1;
                2'b01:   fifo_count <= fifo_count - 5'd1;
                default: fifo_count <= fifo_count;
            endcase
        end
    end

    // Sticky overflow: a dropped push counts as an error only while the run is live.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            ovf_err <= 1'b0;
        end else if (host_valid && !host_ready && !sched_done) begin
            ovf_err <= 1'b1;
        end
    end

    // Issue sequencer: strobe, wait for busy to rise (bounded), wait for it to fall.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state         <= IDLE;
            lcd_cmd       <= 4'd0;
            lcd_cmd_valid <= 1'b0;
            issued_cnt    <= 8'd0;
            sched_done    <= 1'b0;
            is_write      <= 1'b0;
            tmr           <= '0;
        end else begin
            lcd_cmd_valid <= 1'b0;
            case (state)
                IDLE: begin
                    if (fifo_count != 5'd0 && !lcd_busy) begin
                        state         <= ISSUE;
                        lcd_cmd       <= mem[rd_ptr];
                        lcd_cmd_valid <= 1'b1;
                        is_write      <= (mem[rd_ptr] == CMD_WRITE);
                    end
                end
                ISSUE: begin
                    state <= WAIT_BUSY;
                    tmr   <= '0;
                    if (issued_cnt != 8'hFF) issued_cnt <= issued_cnt + 8'd1;
                end
                WAIT_BUSY: begin
                    if (lcd_done && is_write) begin
                        state      <= FINISH;
                        sched_done <= 1'b1;
                    end else if (lcd_busy) begin
                        state <= WAIT_IDLE;
                    end else if (tmr == TW'(BUSY_WIN - 1)) begin
                        // Controller never acknowledged; do not stall forever.
                        state <= is_write ? WAIT_DONE : IDLE;
                    end else begin
                        tmr <= tmr + 1'b1;
                    end
                end
                WAIT_IDLE: begin
                    if (lcd_done && is_write) begin
                        state      <= FINISH;
                        sched_done <= 1'b1;
                    end else if (!lcd_busy) begin
                        state <= is_write ? WAIT_DONE : IDLE;
                    end
                end
                WAIT_DONE: begin
                    if (lcd_done) begin
                        state      <= FINISH;
                        sched_done <= 1'b1;
                    end
                end
                FINISH: begin
                    state <= FINISH;
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule
